vu_viu_issue_seq: RTL and testbench

Element sequencer directly upstream of the banked vector integer ALU.
- Accepts one vector integer command at a time.
- Walks element index 0..vlen-1 and issues register-file operand reads.
- Presents val/wen/fn/utidx to the ALU, aligned with operand arrival.
- Carries the destination write address through a 2-stage shadow pipeline so it lines up with the ALU's registered result.

---
 rtl/vu_viu_issue_seq_pkg.sv | 8 +
 rtl/vu_viu_issue_pipe.sv | 36 +++
 rtl/vu_viu_issue_seq.sv | 116 +++++++++++
 tb/tb_vu_viu_issue_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vu_viu_issue_seq_pkg.sv
// vu_viu_issue_seq_pkg: shared widths and FSM state encoding for the VIU issue sequencer.
//   SZ_VIU_FN / SZ_VLEN : existing VIU function-word and element-index widths
//   state_e             : sequencer states IDLE, ISSUE, DRAIN
package vu_viu_issue_seq_pkg;
    localparam int SZ_VIU_FN = 11;
    localparam int SZ_VLEN = 11;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
endpackage

// File: rtl/vu_viu_issue_pipe.sv
// vu_viu_issue_pipe: s1/s2 valid+payload shift register aligning utidx and write address with the ALU.
//   clk, reset          : clock, synchronous active-high reset (clears valids only)
//   in_val/in_wen       : issue strobe from the sequencer, latched write enable
//   in_utidx/in_waddr   : element index and destination address of the issued element
//   s1_val/s1_utidx     : operand-read stage, feeds the ALU controls
//   s2_val/s2_waddr     : ALU stage, feeds write-back
module vu_viu_issue_pipe #(
    parameter int VLEN_W = 11,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_val,
    input  logic              in_wen,
    input  logic [VLEN_W-1:0] in_utidx,
    input  logic [ADDR_W-1:0] in_waddr,
    output logic              s1_val,
    output logic [VLEN_W-1:0] s1_utidx,
    output logic              s2_val,
    output logic [ADDR_W-1:0] s2_waddr
);
    logic [ADDR_W-1:0] s1_waddr;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_val <= 1'b0;
            s2_val <= 1'b0;
        end else begin
            s1_val <= in_val;
            s2_val <= s1_val & in_wen;
        end
        s1_utidx <= in_utidx;
        s1_waddr <= in_waddr;
        s2_waddr <= s1_waddr;
    end
endmodule

// File: rtl/vu_viu_issue_seq.sv
// vu_viu_issue_seq: element sequencer feeding operand reads and controls to the banked vector integer ALU.
//   cmd_*          : one-at-a-time command handshake (fn, vlen, wen, source/destination bases)
//   stall          : bank/port conflict, blocks new issue only
//   rd_en/rd_addrK : register-file operand reads, baseK + element index
//   alu_*          : ALU controls, one cycle after the read
//   wb_val/wb_addr : write-back slot, two cycles after the read
//   busy/done      : command in progress / one-cycle drain-complete pulse
module vu_viu_issue_seq
    import vu_viu_issue_seq_pkg::*;
#(
    parameter int FN_W = SZ_VIU_FN,
    parameter int VLEN_W = SZ_VLEN,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_val,
    output logic              cmd_rdy,
    input  logic [FN_W-1:0]   cmd_fn,
    input  logic [VLEN_W:0]   cmd_vlen,
    input  logic              cmd_wen,
    input  logic [ADDR_W-1:0] cmd_base0,
    input  logic [ADDR_W-1:0] cmd_base1,
    input  logic [ADDR_W-1:0] cmd_based,
    input  logic              stall,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic              alu_val,
    output logic              alu_wen,
    output logic [FN_W-1:0]   alu_fn,
    output logic [VLEN_W-1:0] alu_utidx,
    output logic              wb_val,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              busy,
    output logic              done
);
    state_e            state, state_n;
    // cnt is one bit wider than utidx so vlen = 2^VLEN_W reaches its last element without wrapping
    logic [VLEN_W:0]   cnt, cnt_n, vlen_q;
    logic [FN_W-1:0]   fn_q;
    logic              wen_q;
    logic [ADDR_W-1:0] base0_q, base1_q, based_q, cnt_a;
    logic              s1_val;

    assign cnt_a    = ADDR_W'(cnt);
    assign rd_addr0 = base0_q + cnt_a;
    assign rd_addr1 = base1_q + cnt_a;
    assign busy     = state != IDLE;
    assign alu_val  = s1_val;
    assign alu_wen  = s1_val & wen_q;
    assign alu_fn   = fn_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
        if (cmd_rdy && cmd_val) begin
            fn_q    <= cmd_fn;
            vlen_q  <= cmd_vlen;
            wen_q   <= cmd_wen;
            base0_q <= cmd_base0;
            base1_q <= cmd_base1;
            based_q <= cmd_based;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cmd_rdy = 1'b0;
        rd_en   = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_val) begin
                    cnt_n   = '0;
                    state_n = (cmd_vlen != '0) ? ISSUE : DRAIN;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    rd_en   = 1'b1;
                    cnt_n   = cnt + 1'b1;
                    state_n = (cnt == vlen_q - 1'b1) ? DRAIN : ISSUE;
                end
            end
            DRAIN: begin
                // the last element is in s2 once s1 is empty, so write-back completes this cycle
                if (!s1_val) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    vu_viu_issue_pipe #(.VLEN_W(VLEN_W), .ADDR_W(ADDR_W)) u_pipe (
        .clk      (clk),
        .reset    (reset),
        .in_val   (rd_en),
        .in_wen   (wen_q),
        .in_utidx (cnt[VLEN_W-1:0]),
        .in_waddr (based_q + cnt_a),
        .s1_val   (s1_val),
        .s1_utidx (alu_utidx),
        .s2_val   (wb_val),
        .s2_waddr (wb_addr)
    );
endmodule

// File: tb/tb_vu_viu_issue_seq.sv
// tb_vu_viu_issue_seq: scoreboard bench for the VIU issue sequencer.
module tb_vu_viu_issue_seq;
    localparam int FN_W = 11;
    localparam int VLEN_W = 11;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_val = 1'b0;
    logic              cmd_rdy;
    logic [FN_W-1:0]   cmd_fn = '0;
    logic [VLEN_W:0]   cmd_vlen = '0;
    logic              cmd_wen = 1'b0;
    logic [ADDR_W-1:0] cmd_base0 = '0, cmd_base1 = '0, cmd_based = '0;
    logic              stall = 1'b0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr0, rd_addr1;
    logic              alu_val, alu_wen;
    logic [FN_W-1:0]   alu_fn;
    logic [VLEN_W-1:0] alu_utidx;
    logic              wb_val;
    logic [ADDR_W-1:0] wb_addr;
    logic              busy, done;

    int checks = 0;
    int failures = 0;

    logic [15:0] rd_q[$];
    logic [21:0] alu_q[$];
    logic [7:0]  wb_q[$];

    vu_viu_issue_seq dut (
        .clk(clk), .reset(reset), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_fn(cmd_fn),
        .cmd_vlen(cmd_vlen), .cmd_wen(cmd_wen), .cmd_base0(cmd_base0), .cmd_base1(cmd_base1),
        .cmd_based(cmd_based), .stall(stall), .rd_en(rd_en), .rd_addr0(rd_addr0),
        .rd_addr1(rd_addr1), .alu_val(alu_val), .alu_wen(alu_wen), .alu_fn(alu_fn),
        .alu_utidx(alu_utidx), .wb_val(wb_val), .wb_addr(wb_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (rd_en) begin
                checks++;
                if (rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL rd_unexpected got=%h/%h required=none", rd_addr0, rd_addr1);
                end else begin
                    logic [15:0] e;
                    e = rd_q.pop_front();
                    if ({rd_addr0, rd_addr1} !== e) begin
                        failures++;
                        $display("FAIL rd_addr got=%h required=%h", {rd_addr0, rd_addr1}, e);
                    end
                end
            end
            if (alu_val) begin
                checks++;
                if (alu_q.size() == 0) begin
                    failures++;
                    $display("FAIL alu_unexpected got utidx=%0d required=none", alu_utidx);
                end else begin
                    logic [21:0] e;
                    e = alu_q.pop_front();
                    if ({alu_utidx, alu_fn} !== e) begin
                        failures++;
                        $display("FAIL alu_utidx_fn got=%h required=%h", {alu_utidx, alu_fn}, e);
                    end
                end
            end
            if (wb_val) begin
                checks++;
                if (wb_q.size() == 0) begin
                    failures++;
                    $display("FAIL wb_unexpected got=%h required=none", wb_addr);
                end else begin
                    logic [7:0] e;
                    e = wb_q.pop_front();
                    if (wb_addr !== e) begin
                        failures++;
                        $display("FAIL wb_addr got=%h required=%h", wb_addr, e);
                    end
                end
            end
        end
    end

    task automatic run_cmd(input int vlen, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] bd, input logic w, input logic [10:0] fn,
                           input logic [31:0] stall_m, input int max_cyc,
                           output int done_cyc, output int rdy_cyc, output int n_done,
                           output logic [31:0] rd_m, output logic [31:0] alu_m,
                           output logic [31:0] wen_m, output logic [31:0] wb_m,
                           output logic [31:0] busy_m);
        for (int i = 0; i < vlen; i++) begin
            rd_q.push_back({b0 + 8'(i), b1 + 8'(i)});
            alu_q.push_back({11'(i), fn});
            if (w) wb_q.push_back(bd + 8'(i));
        end
        @(posedge clk); #1;
        cmd_val = 1'b1; cmd_vlen = 12'(vlen); cmd_base0 = b0; cmd_base1 = b1;
        cmd_based = bd; cmd_wen = w; cmd_fn = fn; stall = stall_m[0];
        done_cyc = -1; rdy_cyc = -1; n_done = 0;
        rd_m = '0; alu_m = '0; wen_m = '0; wb_m = '0; busy_m = '0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (c < 32) begin
                rd_m[c] = rd_en; alu_m[c] = alu_val; wen_m[c] = alu_wen;
                wb_m[c] = wb_val; busy_m[c] = busy;
            end
            if (done) n_done++;
            if (done && done_cyc < 0) done_cyc = c;
            if (c > 0 && cmd_rdy && rdy_cyc < 0) rdy_cyc = c;
            @(posedge clk); #1;
            cmd_val = 1'b0;
            stall = (c + 1 < 32) ? stall_m[c + 1] : 1'b0;
            if (rdy_cyc >= 0) break;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL reset_cmd_rdy got=%b required=1", cmd_rdy); end
        if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b required=0", rd_en); end
        if (alu_val !== 1'b0) begin failures++; $display("FAIL reset_alu_val got=%b required=0", alu_val); end
        if (wb_val !== 1'b0) begin failures++; $display("FAIL reset_wb_val got=%b required=0", wb_val); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b required=0", done); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic check_common(input string name, input int done_cyc, input int exp_done,
                                input int rdy_cyc, input int n_done);
        checks += 4;
        if (done_cyc !== exp_done) begin failures++; $display("FAIL %s_done_cycle got=%0d required=%0d", name, done_cyc, exp_done); end
        if (rdy_cyc !== exp_done + 1) begin failures++; $display("FAIL %s_rdy_cycle got=%0d required=%0d", name, rdy_cyc, exp_done + 1); end
        if (n_done !== 1) begin failures++; $display("FAIL %s_done_count got=%0d required=1", name, n_done); end
        if (rd_q.size() + alu_q.size() + wb_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got=%0d/%0d/%0d required=0/0/0", name, rd_q.size(), alu_q.size(), wb_q.size());
        end
    endtask

    task automatic test_basic;
        int d, r, n;
        logic [31:0] rm, am, wm, bm, ym;
        run_cmd(4, 8'h10, 8'h20, 8'h30, 1'b1, 11'h5A3, 32'h0, 30, d, r, n, rm, am, wm, bm, ym);
        check_common("basic", d, 6, r, n);
        checks += 5;
        if (rm !== 32'h1E) begin failures++; $display("FAIL basic_rd_mask got=%h required=%h", rm, 32'h1E); end
        if (am !== 32'h3C) begin failures++; $display("FAIL basic_alu_mask got=%h required=%h", am, 32'h3C); end
        if (wm !== 32'h3C) begin failures++; $display("FAIL basic_wen_mask got=%h required=%h", wm, 32'h3C); end
        if (bm !== 32'h78) begin failures++; $display("FAIL basic_wb_mask got=%h required=%h", bm, 32'h78); end
        if (ym !== 32'h7E) begin failures++; $display("FAIL basic_busy_mask got=%h required=%h", ym, 32'h7E); end
    endtask

    task automatic test_stall;
        int d, r, n;
        logic [31:0] rm, am, wm, bm, ym;
        run_cmd(4, 8'h10, 8'h20, 8'h30, 1'b1, 11'h1C7, 32'h0C, 30, d, r, n, rm, am, wm, bm, ym);
        check_common("stall", d, 8, r, n);
        checks += 3;
        if (rm !== 32'h72) begin failures++; $display("FAIL stall_rd_mask got=%h required=%h", rm, 32'h72); end
        if (am !== 32'hE4) begin failures++; $display("FAIL stall_alu_mask got=%h required=%h", am, 32'hE4); end
        if (bm !== 32'h1C8) begin failures++; $display("FAIL stall_wb_mask got=%h required=%h", bm, 32'h1C8); end
    endtask

    task automatic test_last_stall;
        int d, r, n;
        logic [31:0] rm, am, wm, bm, ym;
        run_cmd(2, 8'h40, 8'h50, 8'h60, 1'b1, 11'h00F, 32'h0C, 30, d, r, n, rm, am, wm, bm, ym);
        check_common("last_stall", d, 6, r, n);
        checks += 1;
        if (rm !== 32'h12) begin failures++; $display("FAIL last_stall_rd_mask got=%h required=%h", rm, 32'h12); end
    endtask

    task automatic test_vlen0;
        int d, r, n;
        logic [31:0] rm, am, wm, bm, ym;
        run_cmd(0, 8'h10, 8'h20, 8'h30, 1'b1, 11'h123, 32'hFFFF_FFFF, 30, d, r, n, rm, am, wm, bm, ym);
        check_common("vlen0", d, 1, r, n);
        checks += 2;
        if ((rm | am | bm) !== 32'h0) begin failures++; $display("FAIL vlen0_valids got=%h required=0", rm | am | bm); end
        if (ym !== 32'h2) begin failures++; $display("FAIL vlen0_busy_mask got=%h required=%h", ym, 32'h2); end
    endtask

    task automatic test_wrap;
        int d, r, n;
        logic [31:0] rm, am, wm, bm, ym;
        run_cmd(3, 8'hFF, 8'hFD, 8'hFE, 1'b1, 11'h7FF, 32'h0, 30, d, r, n, rm, am, wm, bm, ym);
        check_common("wrap", d, 5, r, n);
        checks += 1;
        if (bm !== 32'h38) begin failures++; $display("FAIL wrap_wb_mask got=%h required=%h", bm, 32'h38); end
    endtask

    task automatic test_nowen;
        int d, r, n;
        logic [31:0] rm, am, wm, bm, ym;
        run_cmd(2, 8'h01, 8'h02, 8'h03, 1'b0, 11'h2AA, 32'h0, 30, d, r, n, rm, am, wm, bm, ym);
        check_common("nowen", d, 4, r, n);
        checks += 3;
        if (am !== 32'h0C) begin failures++; $display("FAIL nowen_alu_mask got=%h required=%h", am, 32'h0C); end
        if (wm !== 32'h0) begin failures++; $display("FAIL nowen_wen_mask got=%h required=0", wm); end
        if (bm !== 32'h0) begin failures++; $display("FAIL nowen_wb_mask got=%h required=0", bm); end
    endtask

    task automatic test_max_vlen;
        int d, r, n;
        logic [31:0] rm, am, wm, bm, ym;
        run_cmd(2048, 8'h80, 8'h00, 8'hC0, 1'b1, 11'h3E1, 32'h0, 2200, d, r, n, rm, am, wm, bm, ym);
        check_common("max_vlen", d, 2050, r, n);
    endtask

    task automatic test_reset_mid;
        int bad;
        for (int i = 0; i < 8; i++) begin
            rd_q.push_back({8'h10 + 8'(i), 8'h20 + 8'(i)});
            alu_q.push_back({11'(i), 11'h0AB});
            wb_q.push_back(8'h30 + 8'(i));
        end
        @(posedge clk); #1;
        cmd_val = 1'b1; cmd_vlen = 12'd8; cmd_base0 = 8'h10; cmd_base1 = 8'h20;
        cmd_based = 8'h30; cmd_wen = 1'b1; cmd_fn = 11'h0AB; stall = 1'b0;
        @(posedge clk); #1;
        cmd_val = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rd_q.delete(); alu_q.delete(); wb_q.delete();
        @(negedge clk);
        checks += 2;
        if ({rd_en, alu_val, wb_val, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL rstmid_valids got=%b required=00000", {rd_en, alu_val, wb_val, busy, done});
        end
        if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL rstmid_cmd_rdy got=%b required=1", cmd_rdy); end
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || !cmd_rdy || rd_en || alu_val || wb_val) bad++;
        end
        checks += 1;
        if (bad != 0) begin failures++; $display("FAIL rstmid_quiet got=%0d bad cycles required=0", bad); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_last_stall;
        test_vlen0;
        test_wrap;
        test_nowen;
        test_max_vlen;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
